// File: rtl/ecc_30_rd_chk.sv
// Read-side ECC check stage for the 30-bit RAM path.
// Two-stage valid/ready pipeline: S1 holds the raw stored word and its
// address, S2 holds the SEC-DED decoded result. Saturating single/double
// error counters and a first-uncorrectable-address capture sit on the
// S1->S2 transfer so each word is accounted for exactly once.
module ecc_30_rd_chk #(
  parameter int DATA_WIDTH   = 30,
  parameter int PARITY_WIDTH = 7,
  parameter int ADDR_WIDTH   = 8,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rd_vld_i,
  output logic                    rd_rdy_o,
  input  logic [DATA_WIDTH-1:0]   rd_data_i,
  input  logic [PARITY_WIDTH-1:0] rd_parity_i,
  input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
  input  logic                    bypass_i,
  output logic                    out_vld_o,
  input  logic                    out_rdy_i,
  output logic [DATA_WIDTH-1:0]   out_data_o,
  output logic                    out_sbit_o,
  output logic                    out_dbit_o,
  input  logic                    cnt_clr_i,
  output logic [CNT_WIDTH-1:0]    sbit_cnt_o,
  output logic [CNT_WIDTH-1:0]    dbit_cnt_o,
  output logic [ADDR_WIDTH-1:0]   err_addr_o,
  output logic                    err_addr_vld_o
);

  localparam int unsigned DW = DATA_WIDTH;

  // Parity-check matrix columns, one per data bit. Each is an extended
  // Hamming column folded so that the overall-parity row is expressed over
  // data bits only: every column has odd weight, so any two-bit error gives
  // a nonzero even-weight syndrome that can never alias a data column or a
  // single-hot (check-bit) syndrome.
  localparam logic [PARITY_WIDTH-1:0] H_COL [DATA_WIDTH] = '{
    7'h43, 7'h45, 7'h46, 7'h07, 7'h49, 7'h4A, 7'h0B, 7'h4C, 7'h0D, 7'h0E,
    7'h4F, 7'h51, 7'h52, 7'h13, 7'h54, 7'h15, 7'h16, 7'h57, 7'h58, 7'h19,
    7'h1A, 7'h5B, 7'h1C, 7'h5D, 7'h5E, 7'h1F, 7'h61, 7'h62, 7'h23, 7'h64
  };

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // Stage 1 registers
  logic                    run_q;
  logic                    s1_vld;
  logic [DATA_WIDTH-1:0]   s1_data;
  logic [PARITY_WIDTH-1:0] s1_par;
  logic [ADDR_WIDTH-1:0]   s1_addr;

  // Handshake
  logic rd_acc;
  logic s2_load;

  // Decode results
  logic [PARITY_WIDTH-1:0] calc_par;
  logic [PARITY_WIDTH-1:0] syn;
  logic [DATA_WIDTH-1:0]   flip_mask;
  logic                    col_hit;
  logic                    single_hot;
  logic [DATA_WIDTH-1:0]   dec_data;
  logic                    dec_sbit;
  logic                    dec_dbit;

  // Events on the S1->S2 transfer
  logic sbit_evt;
  logic dbit_evt;

  // S2 advances when it is empty or being drained; S1 can take a new word
  // when empty or emptying into S2. run_q keeps the port closed until the
  // first clock after reset release.
  always_comb begin
    s2_load  = s1_vld & (~out_vld_o | out_rdy_i);
    rd_rdy_o = run_q & (~s1_vld | s2_load);
    rd_acc   = rd_vld_i & rd_rdy_o;
  end

  // Ready enable: opens one cycle after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // Stage 1: capture raw stored word and address on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_data <= '0;
      s1_par  <= '0;
      s1_addr <= '0;
    end else begin
      if (rd_acc) begin
        s1_vld  <= 1'b1;
        s1_data <= rd_data_i;
        s1_par  <= rd_parity_i;
        s1_addr <= rd_addr_i;
      end else if (s2_load) begin
        s1_vld  <= 1'b0;
      end
    end
  end

  // Recompute check bits from the stored data and form the syndrome
  always_comb begin
    calc_par = '0;
    for (int unsigned i = 0; i < DW; i++) begin
      if (s1_data[i]) begin
        calc_par = calc_par ^ H_COL[i];
      end
    end
    syn = s1_par ^ calc_par;
  end

  // Classify the syndrome and build the correction mask
  always_comb begin
    flip_mask = '0;
    for (int unsigned i = 0; i < DW; i++) begin
      if (syn == H_COL[i]) begin
        flip_mask[i] = 1'b1;
      end
    end
    col_hit    = |flip_mask;
    single_hot = (syn != '0) && ((syn & (syn - PARITY_WIDTH'(1))) == '0);
  end

  // Decoded output word; bypass passes raw data and suppresses all flags
  always_comb begin
    dec_data = s1_data;
    dec_sbit = 1'b0;
    dec_dbit = 1'b0;
    if (!bypass_i) begin
      dec_data = s1_data ^ flip_mask;
      dec_sbit = col_hit | single_hot;
      dec_dbit = (syn != '0) & ~col_hit & ~single_hot;
    end
    sbit_evt = s2_load & dec_sbit;
    dbit_evt = s2_load & dec_dbit;
  end

  // Stage 2: output register, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_o  <= 1'b0;
      out_data_o <= '0;
      out_sbit_o <= 1'b0;
      out_dbit_o <= 1'b0;
    end else begin
      if (s2_load) begin
        out_vld_o  <= 1'b1;
        out_data_o <= dec_data;
        out_sbit_o <= dec_sbit;
        out_dbit_o <= dec_dbit;
      end else if (out_rdy_i) begin
        out_vld_o  <= 1'b0;
      end
    end
  end

  // Saturating error counters; a clear coinciding with an event leaves 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbit_cnt_o <= '0;
      dbit_cnt_o <= '0;
    end else begin
      if (cnt_clr_i) begin
        sbit_cnt_o <= sbit_evt ? CNT_ONE : '0;
      end else if (sbit_evt && (sbit_cnt_o != '1)) begin
        sbit_cnt_o <= sbit_cnt_o + CNT_ONE;
      end
      if (cnt_clr_i) begin
        dbit_cnt_o <= dbit_evt ? CNT_ONE : '0;
      end else if (dbit_evt && (dbit_cnt_o != '1)) begin
        dbit_cnt_o <= dbit_cnt_o + CNT_ONE;
      end
    end
  end

  // First-uncorrectable address capture; a dbit word transferring with the
  // clear is captured as the new first word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_addr_o     <= '0;
      err_addr_vld_o <= 1'b0;
    end else begin
      if (cnt_clr_i) begin
        err_addr_o     <= dbit_evt ? s1_addr : '0;
        err_addr_vld_o <= dbit_evt;
      end else if (dbit_evt && !err_addr_vld_o) begin
        err_addr_o     <= s1_addr;
        err_addr_vld_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ecc_30_rd_chk.sv
// Scoreboard bench for ecc_30_rd_chk. Words are encoded with an extended
// Hamming codeword built by bit position; expected decode results follow
// from how many bits were deliberately flipped, not from syndrome logic.
module tb_ecc_30_rd_chk;

  localparam int DW = 30;
  localparam int PW = 7;
  localparam int AW = 8;
  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = '1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_vld_i;
  logic          rd_rdy_o;
  logic [DW-1:0] rd_data_i;
  logic [PW-1:0] rd_parity_i;
  logic [AW-1:0] rd_addr_i;
  logic          bypass_i;
  logic          out_vld_o;
  logic          out_rdy_i;
  logic [DW-1:0] out_data_o;
  logic          out_sbit_o;
  logic          out_dbit_o;
  logic          cnt_clr_i;
  logic [CW-1:0] sbit_cnt_o;
  logic [CW-1:0] dbit_cnt_o;
  logic [AW-1:0] err_addr_o;
  logic          err_addr_vld_o;

  always #5 clk = ~clk;

  ecc_30_rd_chk #(
    .DATA_WIDTH  (DW),
    .PARITY_WIDTH(PW),
    .ADDR_WIDTH  (AW),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_vld_i      (rd_vld_i),
    .rd_rdy_o      (rd_rdy_o),
    .rd_data_i     (rd_data_i),
    .rd_parity_i   (rd_parity_i),
    .rd_addr_i     (rd_addr_i),
    .bypass_i      (bypass_i),
    .out_vld_o     (out_vld_o),
    .out_rdy_i     (out_rdy_i),
    .out_data_o    (out_data_o),
    .out_sbit_o    (out_sbit_o),
    .out_dbit_o    (out_dbit_o),
    .cnt_clr_i     (cnt_clr_i),
    .sbit_cnt_o    (sbit_cnt_o),
    .dbit_cnt_o    (dbit_cnt_o),
    .err_addr_o    (err_addr_o),
    .err_addr_vld_o(err_addr_vld_o)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          sbit;
    logic          dbit;
    int unsigned   acc_cyc;
    bit            chk_lat;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;
  int unsigned cyc   = 0;
  int unsigned rdy_mode = 0;   // 0: always ready, 1: random 50%, 2: never

  // Model of counters and capture
  logic [CW-1:0] exp_s = '0;
  logic [CW-1:0] exp_d = '0;
  logic [AW-1:0] exp_addr = '0;
  logic          exp_avld = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Extended Hamming encode: data at non-power-of-two positions 3..36,
  // check bit j covers positions with bit j set, bit 6 is overall parity.
  function automatic logic [PW-1:0] encode(input logic [DW-1:0] d);
    logic          cw [1:36];
    logic [PW-1:0] p;
    int unsigned   k;
    k = 0;
    p = '0;
    for (int unsigned pos = 1; pos <= 36; pos++) begin
      if ((pos & (pos - 1)) == 0) cw[pos] = 1'b0;
      else begin
        cw[pos] = d[k];
        k++;
      end
    end
    for (int unsigned j = 0; j < 6; j++)
      for (int unsigned pos = 1; pos <= 36; pos++)
        if (((pos >> j) & 1) == 1) p[j] = p[j] ^ cw[pos];
    p[6] = ^{d, p[5:0]};
    return p;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CMAX) ? v : v + CW'(1);
  endfunction

  always @(posedge clk) cyc++;

  // Consumer ready pattern, changed just after each rising edge
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_rdy_i = 1'b1;
      1:       out_rdy_i = 1'($urandom_range(1, 0));
      default: out_rdy_i = 1'b0;
    endcase
  end

  // Monitor: pops on every output handshake, and checks hold-while-stalled
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_s, prev_d;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_vld", 64'(out_vld_o), 64'd1);
        check("hold_word", 64'({out_data_o, out_sbit_o, out_dbit_o}),
              64'({prev_data, prev_s, prev_d}));
      end
      if (out_vld_o && out_rdy_i) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 64'(out_vld_o), 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("out_data", 64'(out_data_o), 64'(e.data));
          check("out_sbit", 64'(out_sbit_o), 64'(e.sbit));
          check("out_dbit", 64'(out_dbit_o), 64'(e.dbit));
          if (e.chk_lat) check("latency", 64'(cyc - e.acc_cyc), 64'd2);
        end
      end
      prev_stall = out_vld_o & ~out_rdy_i;
      prev_data  = out_data_o;
      prev_s     = out_sbit_o;
      prev_d     = out_dbit_o;
    end
  end

  // Present one word with nflip bits flipped (indices 0..29 data, 30..36
  // parity) and leave rd_vld_i high just after the accepting edge.
  task automatic send_word(input logic [DW-1:0] d, input logic [AW-1:0] a,
                           input int unsigned nflip, input int unsigned f0,
                           input int unsigned f1, input bit lat);
    logic [DW+PW-1:0] w;
    exp_t             e;
    bit               got;
    w = {encode(d), d};
    if (nflip >= 1) w[f0] = ~w[f0];
    if (nflip >= 2) w[f1] = ~w[f1];
    rd_vld_i    = 1'b1;
    rd_data_i   = w[DW-1:0];
    rd_parity_i = w[DW+PW-1:DW];
    rd_addr_i   = a;
    e.chk_lat = lat;
    if (bypass_i) begin
      e.data = w[DW-1:0]; e.sbit = 1'b0; e.dbit = 1'b0;
    end else if (nflip == 0) begin
      e.data = d; e.sbit = 1'b0; e.dbit = 1'b0;
    end else if (nflip == 1) begin
      e.data = d; e.sbit = 1'b1; e.dbit = 1'b0;
    end else begin
      e.data = w[DW-1:0]; e.sbit = 1'b0; e.dbit = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (rd_rdy_o) got = 1'b1;
    end
    if (!got) begin
      check("accept_timeout", 64'd0, 64'd1);
    end else begin
      e.acc_cyc = cyc;
      sb_q.push_back(e);
      if (e.sbit) exp_s = sat_inc(exp_s);
      if (e.dbit) begin
        exp_d = sat_inc(exp_d);
        if (!exp_avld) begin
          exp_avld = 1'b1;
          exp_addr = a;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    rd_vld_i = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    bit done;
    rd_vld_i = 1'b0;
    rdy_mode = 0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      #1;
      if (sb_q.size() == 0 && !out_vld_o) done = 1'b1;
    end
    if (!done) check("drain_timeout", 64'(sb_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats();
    check("sbit_cnt", 64'(sbit_cnt_o), 64'(exp_s));
    check("dbit_cnt", 64'(dbit_cnt_o), 64'(exp_d));
    check("err_addr_vld", 64'(err_addr_vld_o), 64'(exp_avld));
    check("err_addr", 64'(err_addr_o), 64'(exp_addr));
  endtask

  task automatic clear_cnts();
    cnt_clr_i = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr_i = 1'b0;
    exp_s = '0; exp_d = '0; exp_avld = 1'b0; exp_addr = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_vld"}, 64'(out_vld_o), 64'd0);
    check({tag, "_out_data"}, 64'(out_data_o), 64'd0);
    check({tag, "_flags"}, 64'({out_sbit_o, out_dbit_o}), 64'd0);
    check({tag, "_cnts"}, 64'({sbit_cnt_o, dbit_cnt_o}), 64'd0);
    check({tag, "_err_addr"}, 64'({err_addr_vld_o, err_addr_o}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    int unsigned   nf, f0, f1;
    rst_n = 1'b0; rd_vld_i = 1'b0; rd_data_i = '0; rd_parity_i = '0;
    rd_addr_i = '0; bypass_i = 1'b0; cnt_clr_i = 1'b0; out_rdy_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rd_rdy", 64'(rd_rdy_o), 64'd0);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rd_rdy_after_release", 64'(rd_rdy_o), 64'd1);

    // 1) clean words, back to back, latency checked
    for (int unsigned i = 0; i < 8; i++)
      send_word(DW'($urandom), AW'(i), 0, 0, 0, 1'b1);
    drain();
    check_stats();

    // 2) single data-bit error on bit 0
    send_word(30'h1555_5555, 8'h09, 1, 0, 0, 1'b1);
    drain();
    check_stats();

    // 3) two double-bit words; first address is kept
    send_word(DW'($urandom), 8'h2A, 2, 3, 17, 1'b0);
    send_word(DW'($urandom), 8'h30, 2, 32, 11, 1'b0);
    drain();
    check_stats();
    check("capture_first", 64'(err_addr_o), 64'h2A);
    clear_cnts();
    check_stats();

    // 4) random stream with random back-pressure
    rdy_mode = 1;
    for (int unsigned i = 0; i < 20; i++) begin
      nf = $urandom_range(2, 0);
      f0 = $urandom_range(36, 0);
      f1 = (f0 + $urandom_range(36, 1)) % 37;
      send_word(DW'($urandom), AW'($urandom), nf, f0, f1, 1'b0);
      if ($urandom_range(3, 0) == 0) idle($urandom_range(3, 1));
    end
    drain();
    check_stats();

    // 5) saturation, then clear coinciding with an event
    clear_cnts();
    for (int unsigned i = 0; i < 17; i++)
      send_word(DW'($urandom), AW'(i), 1, $urandom_range(36, 0), 0, 1'b0);
    drain();
    check("sbit_saturated", 64'(sbit_cnt_o), 64'(CMAX));
    check_stats();
    send_word(DW'($urandom), 8'h01, 1, 5, 0, 1'b0);
    rd_vld_i  = 1'b0;
    cnt_clr_i = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr_i = 1'b0;
    exp_s = CW'(1); exp_d = '0; exp_avld = 1'b0; exp_addr = '0;
    drain();
    check_stats();
    send_word(DW'($urandom), 8'h77, 2, 1, 33, 1'b0);
    rd_vld_i  = 1'b0;
    cnt_clr_i = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr_i = 1'b0;
    exp_s = '0; exp_d = CW'(1); exp_avld = 1'b1; exp_addr = 8'h77;
    drain();
    check_stats();

    // 6a) bypass with a double-bit word
    bypass_i = 1'b1;
    send_word(DW'($urandom), 8'h55, 2, 4, 20, 1'b0);
    drain();
    bypass_i = 1'b0;
    check_stats();

    // 6b) reset with two words in flight
    rdy_mode = 2;
    @(posedge clk);
    #1;
    send_word(DW'($urandom), 8'hA0, 0, 0, 0, 1'b0);
    send_word(DW'($urandom), 8'hA1, 1, 7, 0, 1'b0);
    rd_vld_i = 1'b0;
    rst_n = 1'b0;
    sb_q.delete();
    exp_s = '0; exp_d = '0; exp_avld = 1'b0; exp_addr = '0;
    @(negedge clk);
    check_all_zero("midreset");
    check("midreset_rd_rdy", 64'(rd_rdy_o), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy_mode = 0;
    repeat (8) @(negedge clk);
    check_all_zero("post_reset");
    check("post_reset_queue", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
